// File: rtl/multicycle_control.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/write-back and
// drives per-cycle datapath controls, with wait-state timeout and illegal-opcode detection.
module multicycle_control #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    output logic        pc_wr,
    output logic        pc_wr_cond,
    output logic        ir_wr,
    output logic        i_or_d,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  reg_dst,
    output logic        mem_to_reg,
    output logic        reg_wr,
    output logic        ext_op,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  pc_src,
    output logic [3:0]  alu_op,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic        fault
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_FAULT     = 4'd15
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101000;

    state_t            state_q;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [5:0]        opcode;
    logic              timeout;

    assign opcode  = inst[31:26];
    assign timeout = (wait_cnt == WAIT_W'(WAIT_LIMIT));

    // ALU operation for the opcodes that use the ALU in EXEC/BRANCH
    function automatic logic [3:0] alu_code(input logic [5:0] op);
        case (op)
            OP_R:     alu_code = 4'b0100;
            OP_ADDI:  alu_code = 4'b0101;
            OP_ANDI:  alu_code = 4'b0011;
            OP_ORI:   alu_code = 4'b0010;
            OP_XORI:  alu_code = 4'b0111;
            OP_SLTI:  alu_code = 4'b1010;
            OP_SLTIU: alu_code = 4'b1011;
            OP_BEQ:   alu_code = 4'b0001;
            OP_BNE:   alu_code = 4'b1001;
            OP_BLEZ:  alu_code = 4'b1000;
            OP_BGTZ:  alu_code = 4'b0110;
            default:  alu_code = 4'b0000;
        endcase
    endfunction

    // State register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic; mem_ready wins over a coincident timeout
    always_comb begin
        state_nxt = state_q;
        wait_nxt  = wait_cnt;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (inst == 32'd0) begin
                    state_nxt = S_FETCH;
                end else begin
                    case (opcode)
                        OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
                            state_nxt = S_EXEC;
                        OP_LW, OP_SW:
                            state_nxt = S_MEM_ADDR;
                        OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                            state_nxt = S_BRANCH;
                        OP_J, OP_JAL:
                            state_nxt = S_JUMP;
                        default:
                            state_nxt = S_FETCH;
                    endcase
                end
            end
            S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready)    state_nxt = S_MEM_WB;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_MEM_WRITE: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_EXEC:      state_nxt = S_ALU_WB;
            S_MEM_WB,
            S_ALU_WB,
            S_BRANCH,
            S_JUMP:      state_nxt = S_FETCH;
            S_FAULT:     state_nxt = S_FAULT;
            default:     state_nxt = S_FETCH;
        endcase

        // Counter restarts on any state change and counts stalled cycles otherwise
        if (state_nxt != state_q) begin
            wait_nxt = '0;
        end else if (state_q == S_FETCH || state_q == S_MEM_READ || state_q == S_MEM_WRITE) begin
            wait_nxt = wait_cnt + WAIT_W'(1);
        end
    end

    // Moore outputs (FETCH strobes and DECODE/MEM_WRITE pulses also qualified by inputs)
    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        ir_wr      = 1'b0;
        i_or_d     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_dst    = 2'b00;
        mem_to_reg = 1'b0;
        reg_wr     = 1'b0;
        ext_op     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = 4'b0000;
        instr_done = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        state      = 4'(state_q);
        case (state_q)
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = 2'b01;
                pc_wr     = mem_ready;
                ir_wr     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (inst == 32'd0) begin
                    instr_done = 1'b1;
                end else begin
                    case (opcode)
                        OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU,
                        OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL: ;
                        default: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = (opcode == OP_R) ? 2'b00 : 2'b10;
                ext_op    = (opcode == OP_SLTI);
                alu_op    = alu_code(opcode);
            end
            S_ALU_WB: begin
                reg_wr     = 1'b1;
                reg_dst    = (opcode == OP_R) ? 2'b01 : 2'b00;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ext_op    = 1'b1;
            end
            S_MEM_READ: begin
                mem_rd = 1'b1;
                i_or_d = 1'b1;
            end
            S_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_wr     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                pc_wr_cond = 1'b1;
                pc_src     = 2'b01;
                alu_op     = alu_code(opcode);
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_wr      = 1'b1;
                pc_src     = 2'b10;
                instr_done = 1'b1;
                if (opcode == OP_JAL) begin
                    reg_wr  = 1'b1;
                    reg_dst = 2'b10;
                end
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase

        // Reset silences everything immediately, including mid-write
        if (rst) begin
            pc_wr      = 1'b0;
            pc_wr_cond = 1'b0;
            ir_wr      = 1'b0;
            i_or_d     = 1'b0;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            reg_dst    = 2'b00;
            mem_to_reg = 1'b0;
            reg_wr     = 1'b0;
            ext_op     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_op     = 4'b0000;
            instr_done = 1'b0;
            illegal    = 1'b0;
            fault      = 1'b0;
            state      = 4'd0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are
// queued with their stimulus and compared as the FSM steps through each instruction.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_wr;
        logic       pc_wr_cond;
        logic       ir_wr;
        logic       i_or_d;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       ext_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [3:0] state;
        logic       instr_done;
        logic       illegal;
        logic       fault;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        mem_ready;
    logic        pc_wr, pc_wr_cond, ir_wr, i_or_d, mem_rd, mem_wr;
    logic [1:0]  reg_dst, alu_src_b, pc_src;
    logic        mem_to_reg, reg_wr, ext_op, alu_src_a;
    logic [3:0]  alu_op, state;
    logic        instr_done, illegal, fault;
    ctl_t        obs;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    ctl_t        exp_q[$];
    logic [31:0] inst_q[$];
    logic        rdy_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.WAIT_LIMIT(15), .WAIT_W(4)) dut (
        .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
        .pc_wr(pc_wr), .pc_wr_cond(pc_wr_cond), .ir_wr(ir_wr),
        .i_or_d(i_or_d), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr),
        .ext_op(ext_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_op(alu_op), .state(state),
        .instr_done(instr_done), .illegal(illegal), .fault(fault)
    );

    assign obs = {pc_wr, pc_wr_cond, ir_wr, i_or_d, mem_rd, mem_wr, reg_dst,
                  mem_to_reg, reg_wr, ext_op, alu_src_a, alu_src_b, pc_src,
                  alu_op, state, instr_done, illegal, fault};

    task automatic check(input string tag, input logic [26:0] got, input logic [26:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, want);
    endtask

    // Expected control vector per state
    function automatic ctl_t e_fetch(input logic r);
        ctl_t c = '0;
        c.mem_rd = 1'b1; c.alu_src_b = 2'b01; c.pc_wr = r; c.ir_wr = r;
        return c;
    endfunction
    function automatic ctl_t e_decode(input logic done, input logic ill);
        ctl_t c = '0;
        c.state = 4'd1; c.alu_src_b = 2'b11; c.instr_done = done; c.illegal = ill;
        return c;
    endfunction
    function automatic ctl_t e_exec(input logic rt, input logic [3:0] aop, input logic ext);
        ctl_t c = '0;
        c.state = 4'd6; c.alu_src_a = 1'b1; c.alu_src_b = rt ? 2'b00 : 2'b10;
        c.alu_op = aop; c.ext_op = ext;
        return c;
    endfunction
    function automatic ctl_t e_alu_wb(input logic rt);
        ctl_t c = '0;
        c.state = 4'd7; c.reg_wr = 1'b1; c.reg_dst = rt ? 2'b01 : 2'b00; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_mem_addr();
        ctl_t c = '0;
        c.state = 4'd2; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ext_op = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_mem_read();
        ctl_t c = '0;
        c.state = 4'd3; c.mem_rd = 1'b1; c.i_or_d = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_mem_wb();
        ctl_t c = '0;
        c.state = 4'd4; c.reg_wr = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_mem_write(input logic r);
        ctl_t c = '0;
        c.state = 4'd5; c.mem_wr = 1'b1; c.i_or_d = 1'b1; c.instr_done = r;
        return c;
    endfunction
    function automatic ctl_t e_branch(input logic [3:0] aop);
        ctl_t c = '0;
        c.state = 4'd8; c.alu_src_a = 1'b1; c.pc_wr_cond = 1'b1; c.pc_src = 2'b01;
        c.alu_op = aop; c.instr_done = 1'b1;
        return c;
    endfunction
    function automatic ctl_t e_jump(input logic link);
        ctl_t c = '0;
        c.state = 4'd9; c.pc_wr = 1'b1; c.pc_src = 2'b10; c.instr_done = 1'b1;
        c.reg_wr = link; c.reg_dst = link ? 2'b10 : 2'b00;
        return c;
    endfunction
    function automatic ctl_t e_fault();
        ctl_t c = '0;
        c.state = 4'd15; c.fault = 1'b1;
        return c;
    endfunction

    task automatic push(input logic [31:0] i, input logic r, input ctl_t e);
        inst_q.push_back(i);
        rdy_q.push_back(r);
        exp_q.push_back(e);
    endtask

    // Called at a falling edge; applies one cycle of stimulus per queued entry
    task automatic drain(input string tag);
        int   n = 0;
        ctl_t e;
        while (exp_q.size() > 0) begin
            inst      = inst_q.pop_front();
            mem_ready = rdy_q.pop_front();
            e         = exp_q.pop_front();
            #1;
            check($sformatf("%s[%0d]", tag, n), obs, e);
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [31:0] i;
        rst = 1'b1; inst = 32'h0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset", obs, '0);
        mem_ready = 1'b1; inst = 32'h2022_0005;
        #1 check("reset_ready", obs, '0);
        @(negedge clk) rst = 1'b0;

        // addi, zero wait
        i = 32'h2022_0005;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0));
        push(i, 1, e_exec(0, 4'b0101, 0)); push(i, 1, e_alu_wb(0));
        drain("addi");

        // load with three MEM_READ wait states; mem_ready ignored elsewhere
        i = 32'h8022_0004;
        push(i, 1, e_fetch(1)); push(i, 0, e_decode(0, 0)); push(i, 1, e_mem_addr());
        for (int k = 0; k < 3; k++) push(i, 0, e_mem_read());
        push(i, 1, e_mem_read()); push(i, 0, e_mem_wb());
        drain("load");

        // jal, bne, nop
        i = 32'h0C00_0010;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_jump(1));
        i = 32'h1422_0003;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_branch(4'b1001));
        i = 32'h0000_0000;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(1, 0));
        drain("jal_bne_nop");

        // R-type, slti, j, beq
        i = 32'h0022_1820;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0));
        push(i, 1, e_exec(1, 4'b0100, 0)); push(i, 1, e_alu_wb(1));
        i = 32'h2822_0005;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0));
        push(i, 1, e_exec(0, 4'b1010, 1)); push(i, 1, e_alu_wb(0));
        i = 32'h0800_0020;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_jump(0));
        i = 32'h1022_0002;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_branch(4'b0001));
        drain("rtype_slti_j_beq");

        // store with one fetch wait and one write wait
        i = 32'hA022_0004;
        push(i, 0, e_fetch(0)); push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0));
        push(i, 1, e_mem_addr()); push(i, 0, e_mem_write(0)); push(i, 1, e_mem_write(1));
        drain("store");

        // illegal opcode
        i = 32'hFC00_0000;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(1, 1));
        drain("illegal");

        // mem_ready arriving in the limit cycle beats the timeout
        i = 32'h0000_0000;
        for (int k = 0; k < 15; k++) push(i, 0, e_fetch(0));
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(1, 0));
        drain("limit_race");

        // store never acknowledged: 16 MEM_WRITE cycles, then sticky fault
        i = 32'hA022_0004;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_mem_addr());
        for (int k = 0; k < 16; k++) push(i, 0, e_mem_write(0));
        for (int k = 0; k < 3; k++) push(i, k[0], e_fault());
        drain("timeout");

        // recovery from fault only via reset
        #2 rst = 1'b1;
        #1 check("fault_reset", obs, '0);
        @(negedge clk) rst = 1'b0;
        i = 32'h2022_0005;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0));
        push(i, 1, e_exec(0, 4'b0101, 0)); push(i, 1, e_alu_wb(0));
        i = 32'hA022_0004;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(0, 0)); push(i, 1, e_mem_addr());
        push(i, 0, e_mem_write(0)); push(i, 0, e_mem_write(0));
        drain("pre_abort");

        // reset mid MEM_WRITE drops mem_wr in the same cycle
        #2 rst = 1'b1;
        #1 check("abort_reset", obs, '0);
        @(negedge clk) rst = 1'b0;
        i = 32'h0000_0000;
        push(i, 1, e_fetch(1)); push(i, 1, e_decode(1, 0));
        drain("post_abort");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle control decoder: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back steps and drives the datapath's per-cycle control signals. It sits between the instruction register and the shared-memory multi-cycle datapath. It decodes the same opcode set as the single-cycle decoder, with the same 4-bit ALU operation encoding. It adds memory wait-state handling, a bounded wait timeout, illegal-opcode detection and per-instruction completion reporting.

## Interface
- WAIT_LIMIT, 15: maximum consecutive cycles a memory state may wait for mem_ready before faulting (1..2^WAIT_W-1).
- WAIT_W, 4: width of the wait counter.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst  in  32  instruction register contents; stable from DECODE until return to FETCH.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- pc_wr, pc_wr_cond, ir_wr  out  1 each  PC write, conditional PC write (datapath qualifies it with the ALU condition), IR load.
- i_or_d, mem_rd, mem_wr  out  1 each  memory address select (0 = PC, 1 = ALUOut), read strobe, write strobe.
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31.
- mem_to_reg, reg_wr, ext_op, alu_src_a  out  1 each.
- alu_src_b  out  2  00 = reg B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2.
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- alu_op  out  4  ALU operation.
- state  out  4  current state code, for debug.
- instr_done  out  1  one-cycle pulse in the last cycle of every instruction.
- illegal  out  1  one-cycle pulse in DECODE for an unknown opcode.
- fault  out  1  sticky; set on memory timeout.

## Operation
- State codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, FAULT=15.
- FETCH: mem_rd=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0000, pc_src=00. pc_wr and ir_wr equal mem_ready. Moves to DECODE on mem_ready; otherwise holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=0000. Next state by opcode:
  - inst==0 (nop): FETCH, with instr_done=1.
  - 000000 (R-type) and immediate ALU ops 001000, 001100, 001101, 001110, 001010, 001011: EXEC.
  - 100000 (load) and 101000 (store): MEM_ADDR.
  - 000100, 000101, 000110, 000111 (branches): BRANCH.
  - 000010 (j) and 000011 (jal): JUMP.
  - Anything else: illegal=1, instr_done=1, next state FETCH.
- EXEC: alu_src_a=1. alu_src_b=00 for R-type, 10 for immediates. ext_op=1 only for 001010.
- ALU_WB: reg_wr=1, mem_to_reg=0. reg_dst=01 for R-type, 00 otherwise. instr_done=1. Next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=0000. Next state MEM_READ (load) or MEM_WRITE (store).
- MEM_READ: mem_rd=1, i_or_d=1. Moves to MEM_WB on mem_ready.
- MEM_WB: reg_wr=1, mem_to_reg=1, reg_dst=00, instr_done=1.
- MEM_WRITE: mem_wr=1, i_or_d=1. On mem_ready: instr_done=1, next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, pc_wr_cond=1, pc_src=01, instr_done=1.
- JUMP: pc_wr=1, pc_src=10, instr_done=1. For jal: reg_wr=1, reg_dst=10.
- alu_op in EXEC/BRANCH:
  - R=0100, addi=0101, andi=0011, ori=0010, xori=0111, slti=1010, sltiu=1011.
  - beq=0001, bne=1001, blez=1000, bgtz=0110.
  - In every other state alu_op=0000.
- Any output not listed for a state is 0.
- Wait counter: cleared on entry to FETCH, MEM_READ and MEM_WRITE. Increments each cycle the machine waits there with mem_ready=0.
- Timeout: in the cycle the counter equals WAIT_LIMIT with mem_ready still 0, the next state is FAULT.
- FAULT: all strobes 0, fault=1, holds until rst.

## Timing
- Outputs are combinational from the state register and inst[31:26]. There is no output register.
- While rst=1: state=FETCH, counter=0, fault=0, and all outputs are forced 0.
- First FETCH strobes appear in the first cycle after rst deasserts.
- Cycle counts with zero wait states: R-type/immediate 4, load 5, store 4, branch 3, jump 3, nop 2, illegal 2. Each wait cycle adds 1.
- mem_ready sampled outside FETCH/MEM_READ/MEM_WRITE is ignored.
- mem_ready rising together with the limit cycle: mem_ready wins and there is no fault.
- rst asserted mid-instruction: abort immediately. No write strobe is asserted after the rst edge.

## Test plan
- Reset, then addi (0x20220005) with mem_ready tied to 1 -> states 0,1,6,7. alu_op=0101, alu_src_b=10 in EXEC. reg_wr=1, reg_dst=00 and instr_done=1 in cycle 4.
- Load (0x80220004), mem_ready low for 3 cycles in MEM_READ -> 8 cycles total. mem_rd=i_or_d=1 held throughout. mem_to_reg=reg_wr=1 in MEM_WB.
- Sequence of jal (0x0C000010), bne (0x14220003), nop (0x00000000) -> JUMP with reg_dst=10 and reg_wr=1; BRANCH with alu_op=1001 and pc_wr_cond=1; nop with 2 cycles and no writes.
- Opcode 111111 -> illegal and instr_done pulse in DECODE, return to FETCH, no strobes.
- Store with mem_ready held at 0, WAIT_LIMIT=15 -> fault rises after 16 MEM_WRITE cycles, mem_wr drops. Recovery only via rst.
- rst pulsed during MEM_WRITE -> mem_wr=0 within the same cycle. FETCH resumes after deassert.
